// File: rtl/hilo_div_if.sv
// Stream channels between the HI/LO divide controller and the external divider cores.
// The controller drives the operand channels and receives the result channel.
interface hilo_div_if;
    logic        s_div_dividend_tvalid;
    logic        s_div_dividend_tready;
    logic [31:0] s_div_dividend_tdata;
    logic        s_div_divisor_tvalid;
    logic        s_div_divisor_tready;
    logic [31:0] s_div_divisor_tdata;
    logic        m_div_dout_tvalid;
    logic [63:0] m_div_dout_tdata;

    modport master (
        output s_div_dividend_tvalid,
        output s_div_dividend_tdata,
        input  s_div_dividend_tready,
        output s_div_divisor_tvalid,
        output s_div_divisor_tdata,
        input  s_div_divisor_tready,
        input  m_div_dout_tvalid,
        input  m_div_dout_tdata
    );

    modport slave (
        input  s_div_dividend_tvalid,
        input  s_div_dividend_tdata,
        output s_div_dividend_tready,
        input  s_div_divisor_tvalid,
        input  s_div_divisor_tdata,
        output s_div_divisor_tready,
        output m_div_dout_tvalid,
        output m_div_dout_tdata
    );
endinterface

// File: rtl/hilo_div_ctrl.sv
// Sequences one DIV/DIVU at a time through the external divider cores and writes HI/LO.
//
//   state | meaning
//   IDLE  | no divide in flight; accepts a new request
//   SEND  | operand tvalids up, waiting for both handshakes
//   WAIT  | operands accepted, waiting for the core result
//   DONE  | result written to HI/LO, EX may proceed
//   DRAIN | cancelled divide in the core; swallow its result
module hilo_div_ctrl (
    input  logic              clk,
    input  logic              reset,
    input  logic              es_valid,
    input  logic              es_div_op,
    input  logic              es_divu_op,
    input  logic [31:0]       es_src1,
    input  logic [31:0]       es_src2,
    input  logic              es_fire,
    input  logic              flush,
    output logic              div_stall,
    output logic              div_signed,
    hilo_div_if.master        div_bus,
    output logic              hilo_we,
    output logic [31:0]       hi_wdata,
    output logic [31:0]       lo_wdata
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND  = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic        dvd_valid, dvd_valid_nxt;
    logic        dvs_valid, dvs_valid_nxt;
    logic [31:0] dvd_data, dvd_data_nxt;
    logic [31:0] dvs_data, dvs_data_nxt;
    logic        signed_q, signed_nxt;
    logic        discard, discard_nxt;
    logic        we_q, we_nxt;
    logic [31:0] hi_q, hi_nxt;
    logic [31:0] lo_q, lo_nxt;

    logic req;
    logic dvd_hs;
    logic dvs_hs;
    logic send_done;
    logic dout_hit;

    assign req       = es_valid & (es_div_op | es_divu_op);
    assign dvd_hs    = dvd_valid & div_bus.s_div_dividend_tready;
    assign dvs_hs    = dvs_valid & div_bus.s_div_divisor_tready;
    assign send_done = (~dvd_valid | dvd_hs) & (~dvs_valid | dvs_hs);
    assign dout_hit  = div_bus.m_div_dout_tvalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dvd_valid <= 1'b0;
            dvs_valid <= 1'b0;
            dvd_data  <= 32'd0;
            dvs_data  <= 32'd0;
            signed_q  <= 1'b0;
            discard   <= 1'b0;
            we_q      <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state     <= state_nxt;
            dvd_valid <= dvd_valid_nxt;
            dvs_valid <= dvs_valid_nxt;
            dvd_data  <= dvd_data_nxt;
            dvs_data  <= dvs_data_nxt;
            signed_q  <= signed_nxt;
            discard   <= discard_nxt;
            we_q      <= we_nxt;
            hi_q      <= hi_nxt;
            lo_q      <= lo_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        // A tvalid only ever drops on its own handshake, never on flush.
        dvd_valid_nxt = dvd_valid & ~dvd_hs;
        dvs_valid_nxt = dvs_valid & ~dvs_hs;
        dvd_data_nxt  = dvd_data;
        dvs_data_nxt  = dvs_data;
        signed_nxt    = signed_q;
        discard_nxt   = discard;
        we_nxt        = 1'b0;
        hi_nxt        = hi_q;
        lo_nxt        = lo_q;

        case (state)
            IDLE: begin
                discard_nxt = 1'b0;
                if (req & ~flush) begin
                    dvd_data_nxt  = es_src1;
                    dvs_data_nxt  = es_src2;
                    signed_nxt    = es_div_op;
                    dvd_valid_nxt = 1'b1;
                    dvs_valid_nxt = 1'b1;
                    state_nxt     = SEND;
                end
            end
            SEND: begin
                discard_nxt = discard | flush;
                if (send_done) begin
                    state_nxt = (discard | flush) ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (dout_hit) begin
                    // A flush arriving with the result simply drops it; nothing left to drain.
                    if (flush) begin
                        state_nxt = IDLE;
                    end else begin
                        lo_nxt    = div_bus.m_div_dout_tdata[63:32];
                        hi_nxt    = div_bus.m_div_dout_tdata[31:0];
                        we_nxt    = 1'b1;
                        state_nxt = DONE;
                    end
                end else if (flush) begin
                    state_nxt = DRAIN;
                end
            end
            DONE: begin
                if (es_fire | flush) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (dout_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign div_stall  = req & (state != DONE);
    assign div_signed = signed_q;
    assign hilo_we    = we_q;
    assign hi_wdata   = hi_q;
    assign lo_wdata   = lo_q;

    assign div_bus.s_div_dividend_tvalid = dvd_valid;
    assign div_bus.s_div_dividend_tdata  = dvd_data;
    assign div_bus.s_div_divisor_tvalid  = dvs_valid;
    assign div_bus.s_div_divisor_tdata   = dvs_data;
endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Bench for hilo_div_ctrl: behavioural divider core, directed EX-stage scenarios,
// and a scoreboard monitor that checks every HI/LO write against queued expectations.
module tb_hilo_div_ctrl;
    localparam int CORE_LAT = 4;

    logic        clk;
    logic        reset;
    logic        es_valid;
    logic        es_div_op;
    logic        es_divu_op;
    logic [31:0] es_src1;
    logic [31:0] es_src2;
    logic        es_fire;
    logic        flush;
    logic        div_stall;
    logic        div_signed;
    logic        hilo_we;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;

    hilo_div_if div_bus ();

    hilo_div_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .es_valid   (es_valid),
        .es_div_op  (es_div_op),
        .es_divu_op (es_divu_op),
        .es_src1    (es_src1),
        .es_src2    (es_src2),
        .es_fire    (es_fire),
        .flush      (flush),
        .div_stall  (div_stall),
        .div_signed (div_signed),
        .div_bus    (div_bus),
        .hilo_we    (hilo_we),
        .hi_wdata   (hi_wdata),
        .lo_wdata   (lo_wdata)
    );

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];   // {lo, hi}

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Behavioural divider core: accepts both operands, answers CORE_LAT cycles after the last handshake.
    function automatic logic [63:0] core_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q;
        logic [31:0] r;
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    logic        c_dvd, c_dvs, c_s, r_s;
    logic [31:0] c_a, c_b, r_a, r_b;
    int          c_cnt;

    always @(posedge clk) begin : core_model
        logic        hd, hs, s_t;
        logic [31:0] a_t, b_t;
        div_bus.m_div_dout_tvalid <= 1'b0;
        if (reset) begin
            c_dvd <= 1'b0;
            c_dvs <= 1'b0;
            c_cnt <= 0;
        end else begin
            hd  = c_dvd | (div_bus.s_div_dividend_tvalid & div_bus.s_div_dividend_tready);
            hs  = c_dvs | (div_bus.s_div_divisor_tvalid & div_bus.s_div_divisor_tready);
            a_t = (div_bus.s_div_dividend_tvalid & div_bus.s_div_dividend_tready) ? div_bus.s_div_dividend_tdata : c_a;
            s_t = (div_bus.s_div_dividend_tvalid & div_bus.s_div_dividend_tready) ? div_signed : c_s;
            b_t = (div_bus.s_div_divisor_tvalid & div_bus.s_div_divisor_tready) ? div_bus.s_div_divisor_tdata : c_b;
            if (c_cnt == 1) begin
                div_bus.m_div_dout_tvalid <= 1'b1;
                div_bus.m_div_dout_tdata  <= core_div(r_a, r_b, r_s);
                c_cnt <= 0;
            end else if (c_cnt > 1) begin
                c_cnt <= c_cnt - 1;
            end
            if (hd && hs) begin
                c_dvd <= 1'b0;
                c_dvs <= 1'b0;
                r_a   <= a_t;
                r_b   <= b_t;
                r_s   <= s_t;
                c_cnt <= CORE_LAT - 1;
            end else begin
                c_dvd <= hd;
                c_dvs <= hs;
                c_a   <= a_t;
                c_b   <= b_t;
                c_s   <= s_t;
            end
        end
    end

    // Scoreboard monitor: every HI/LO write must match the oldest queued expectation.
    initial begin : monitor
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (hilo_we === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL hilo_write: unexpected write lo=%08h hi=%08h, required none", lo_wdata, hi_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({lo_wdata, hi_wdata} !== e) begin
                        bad++;
                        $display("FAIL hilo_write: got lo=%08h hi=%08h, required lo=%08h hi=%08h",
                                 lo_wdata, hi_wdata, e[63:32], e[31:0]);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic wait_we(input string name, output int n);
        n = 0;
        while (hilo_we !== 1'b1 && n < 40) begin
            check({name, "_stall_high"}, {63'd0, div_stall}, 64'd1);
            step();
            n++;
        end
        if (hilo_we !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no hilo_we, required one within 40 cycles", name);
        end
    endtask

    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        es_valid   = 1'b1;
        es_div_op  = sgn;
        es_divu_op = ~sgn;
        es_src1    = a;
        es_src2    = b;
    endtask

    task automatic retire();
        es_fire = 1'b1;
        step();
        es_fire    = 1'b0;
        es_valid   = 1'b0;
        es_div_op  = 1'b0;
        es_divu_op = 1'b0;
    endtask

    initial begin : stim
        int n;
        reset      = 1'b1;
        es_valid   = 1'b0;
        es_div_op  = 1'b0;
        es_divu_op = 1'b0;
        es_src1    = 32'd0;
        es_src2    = 32'd0;
        es_fire    = 1'b0;
        flush      = 1'b0;
        div_bus.s_div_dividend_tready = 1'b1;
        div_bus.s_div_divisor_tready  = 1'b1;
        repeat (3) step();

        check("rst_dvd_tvalid", {63'd0, div_bus.s_div_dividend_tvalid}, 64'd0);
        check("rst_dvs_tvalid", {63'd0, div_bus.s_div_divisor_tvalid}, 64'd0);
        check("rst_hilo_we", {63'd0, hilo_we}, 64'd0);
        check("rst_div_signed", {63'd0, div_signed}, 64'd0);
        check("rst_hilo", {lo_wdata, hi_wdata}, 64'd0);
        check("rst_tdata", {div_bus.s_div_dividend_tdata, div_bus.s_div_divisor_tdata}, 64'd0);
        reset = 1'b0;
        step();

        // DIV -7 / 2, both channels ready
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        exp_q.push_back({32'hFFFF_FFFD, 32'hFFFF_FFFF});
        #1;
        check("t1_stall_idle", {63'd0, div_stall}, 64'd1);
        step();
        check("t1_tvalids_up", {62'd0, div_bus.s_div_dividend_tvalid, div_bus.s_div_divisor_tvalid}, 64'd3);
        check("t1_div_signed", {63'd0, div_signed}, 64'd1);
        check("t1_tdata", {div_bus.s_div_dividend_tdata, div_bus.s_div_divisor_tdata}, {32'hFFFF_FFF9, 32'd2});
        step();
        check("t1_tvalids_down", {62'd0, div_bus.s_div_dividend_tvalid, div_bus.s_div_divisor_tvalid}, 64'd0);
        wait_we("t1", n);
        check("t1_latency", 64'(n + 2), 64'(2 + CORE_LAT));
        check("t1_stall_done", {63'd0, div_stall}, 64'd0);
        retire();
        step();
        check("t1_we_single", {63'd0, hilo_we}, 64'd0);

        // DIVU 100 / 7, divisor ready three cycles after the dividend handshake
        div_bus.s_div_divisor_tready = 1'b0;
        issue(1'b0, 32'd100, 32'd7);
        exp_q.push_back({32'd14, 32'd2});
        step();
        check("t2_tvalids_up", {62'd0, div_bus.s_div_dividend_tvalid, div_bus.s_div_divisor_tvalid}, 64'd3);
        step();
        check("t2_dvd_dropped", {63'd0, div_bus.s_div_dividend_tvalid}, 64'd0);
        check("t2_div_signed", {63'd0, div_signed}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("t2_dvs_held", {63'd0, div_bus.s_div_divisor_tvalid}, 64'd1);
            check("t2_dvs_tdata", {32'd0, div_bus.s_div_divisor_tdata}, 64'd7);
            if (i == 2) div_bus.s_div_divisor_tready = 1'b1;
            step();
        end
        check("t2_dvs_dropped", {63'd0, div_bus.s_div_divisor_tvalid}, 64'd0);
        wait_we("t2", n);
        retire();
        step();

        // DIV 20 / -3, DONE held with es_fire low for three cycles
        issue(1'b1, 32'd20, 32'hFFFF_FFFD);
        exp_q.push_back({32'hFFFF_FFFA, 32'd2});
        step();
        wait_we("t3", n);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_hold_we", {63'd0, hilo_we}, 64'd0);
            check("t3_hold_stall", {63'd0, div_stall}, 64'd0);
            check("t3_hold_no_issue", {63'd0, div_bus.s_div_dividend_tvalid}, 64'd0);
        end
        retire();
        step();
        check("t3_idle_no_issue", {63'd0, div_bus.s_div_dividend_tvalid}, 64'd0);

        // DIV 50 / 5 flushed in WAIT; DIV -9 / 4 waits behind the drain
        issue(1'b1, 32'd50, 32'd5);
        step();
        step();
        flush    = 1'b1;
        es_valid = 1'b0;
        step();
        flush = 1'b0;
        issue(1'b1, 32'hFFFF_FFF7, 32'd4);
        exp_q.push_back({32'hFFFF_FFFE, 32'hFFFF_FFFF});
        #1;
        n = 0;
        while (div_bus.s_div_dividend_tvalid !== 1'b1 && n < 20) begin
            check("t4_drain_stall", {63'd0, div_stall}, 64'd1);
            step();
            n++;
        end
        check("t4_drain_cycles", 64'(n), 64'd4);
        check("t4_new_tdata", {32'd0, div_bus.s_div_dividend_tdata}, 64'hFFFF_FFF7);
        wait_we("t4", n);
        retire();
        step();

        // DIVU 77 / 7 flushed in SEND while dividend tready is low
        div_bus.s_div_dividend_tready = 1'b0;
        issue(1'b0, 32'd77, 32'd7);
        step();
        step();
        flush    = 1'b1;
        es_valid = 1'b0;
        check("t5_dvd_wait", {63'd0, div_bus.s_div_dividend_tvalid}, 64'd1);
        check("t5_dvs_done", {63'd0, div_bus.s_div_divisor_tvalid}, 64'd0);
        step();
        flush = 1'b0;
        check("t5_dvd_held", {63'd0, div_bus.s_div_dividend_tvalid}, 64'd1);
        check("t5_dvd_tdata", {32'd0, div_bus.s_div_dividend_tdata}, 64'd77);
        div_bus.s_div_dividend_tready = 1'b1;
        step();
        check("t5_dvd_dropped", {63'd0, div_bus.s_div_dividend_tvalid}, 64'd0);
        repeat (10) step();
        check("t5_no_we", {63'd0, hilo_we}, 64'd0);

        // DIV 1000 / 3 interrupted by reset in WAIT, then DIVU 9 / 3
        issue(1'b1, 32'd1000, 32'd3);
        step();
        step();
        reset    = 1'b1;
        es_valid = 1'b0;
        step();
        check("t6_rst_tvalids", {62'd0, div_bus.s_div_dividend_tvalid, div_bus.s_div_divisor_tvalid}, 64'd0);
        check("t6_rst_we", {63'd0, hilo_we}, 64'd0);
        check("t6_rst_signed", {63'd0, div_signed}, 64'd0);
        check("t6_rst_hilo", {lo_wdata, hi_wdata}, 64'd0);
        check("t6_rst_tdata", {div_bus.s_div_dividend_tdata, div_bus.s_div_divisor_tdata}, 64'd0);
        check("t6_rst_stall", {63'd0, div_stall}, 64'd0);
        reset = 1'b0;
        step();
        issue(1'b0, 32'd9, 32'd3);
        exp_q.push_back({32'd3, 32'd0});
        step();
        wait_we("t6", n);
        retire();
        repeat (10) step();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
